ha_response_compactor: RTL



---
 rtl/ha_bist_pkg.sv | 35 +++
 rtl/ha_misr.sv | 31 +++
 rtl/ha_response_compactor.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ha_bist_pkg.sv
// Shared definitions for the half adder BIST response compactor:
// FSM state encoding, half adder default MISR constants and the MISR step function.
package ha_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ha_state_e;

  localparam int unsigned MISR_MAX_W = 32;

  localparam logic [7:0] HA_POLY   = 8'h1D;
  localparam logic [7:0] HA_SEED   = 8'h00;
  localparam logic [7:0] HA_GOLDEN = 8'h04;

  // One MISR clock: shift left, fold the polynomial in when the MSB falls out,
  // then inject the {carry, sum} response into the two LSBs. Width-generic up to MISR_MAX_W.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] poly,
    input int unsigned           width,
    input logic                  c,
    input logic                  s
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    logic                  msb;
    mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    msb  = |(sig & (MISR_MAX_W'(1) << (width - 1)));
    nxt  = (sig << 1) ^ (msb ? poly : '0) ^ {{(MISR_MAX_W-2){1'b0}}, c, s};
    return nxt & mask;
  endfunction

endpackage

// File: rtl/ha_misr.sv
// SIG_WIDTH-bit multiple-input signature register: seed load and shift enable,
// plus the combinational next value so the caller can compare before the edge lands.
module ha_misr
  import ha_bist_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH = 8,
  parameter logic [SIG_WIDTH-1:0] POLY      = HA_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED      = HA_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 c_in,
  input  logic                 s_in,
  output logic [SIG_WIDTH-1:0] sig,
  output logic [SIG_WIDTH-1:0] sig_next
);

  assign sig_next = SIG_WIDTH'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(POLY),
                                         SIG_WIDTH, c_in, s_in));

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/ha_response_compactor.sv
// Half adder BIST response compactor: MISR over PATTERN_COUNT valid samples, then golden compare.
// Optional watchdog enabled by defining HA_RESPONSE_COMPACTOR_TIMEOUT_EN.
module ha_response_compactor
  import ha_bist_pkg::*;
#(
  parameter int unsigned          SIG_WIDTH      = 8,
  parameter logic [SIG_WIDTH-1:0] POLY           = HA_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED           = HA_SEED,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG     = HA_GOLDEN,
  parameter int unsigned          PATTERN_COUNT  = 4,
  parameter int unsigned          TIMEOUT_CYCLES = 64,
  localparam int unsigned         CNT_W          = $clog2(PATTERN_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 s_in,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_W-1:0]     count
);

  ha_state_e            state, state_next;
  logic                 load, shift, wd_expire;
  logic [SIG_WIDTH-1:0] sig_next;

  ha_misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY),
    .SEED      (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .c_in     (c_in),
    .s_in     (s_in),
    .sig      (signature),
    .sig_next (sig_next)
  );

`ifdef HA_RESPONSE_COMPACTOR_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Counts consecutive RUN cycles without a sample; any valid restarts the window.
  always_ff @(posedge clk) begin
    if (!rst_n || state != RUN || in_valid) begin
      wd <= '0;
    end else begin
      wd <= wd + WD_W'(1);
    end
  end

  assign wd_expire = (state == RUN) && !in_valid && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic wd_unused;
  assign wd_unused = ^TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (in_valid) begin
          shift = 1'b1;
          if (count == CNT_W'(PATTERN_COUNT - 1)) begin
            state_next = DONE;
          end
        end else if (wd_expire) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        count   <= '0;
        pass    <= 1'b0;
        timeout <= 1'b0;
      end else if (shift) begin
        if (count != CNT_W'(PATTERN_COUNT)) begin
          count <= count + CNT_W'(1);
        end
        // Compare the value the MISR is about to hold so pass lands with done.
        if (state_next == DONE) begin
          pass <= (sig_next == GOLDEN_SIG);
        end
      end else if (wd_expire) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
